// File: rtl/ama_riscv_imm_gen_q.sv
// ama_riscv_imm_gen_q: registered RISC-V immediate generator with an output FIFO.
// Decodes I/S/B/J/U immediates from instr[31:7], sign-extends them to XLEN and
// queues them (with an error tag) in a DEPTH-entry circular buffer. A HOLD
// select re-issues the most recent immediate; reserved selects queue a zero
// tagged as an error and latch a sticky flag.
module ama_riscv_imm_gen_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ig_sel,
    input  logic [24:0]     ig_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ig_out,
    output logic            ig_err,
    output logic            err_sticky
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);

    localparam logic [2:0] SEL_HOLD = 3'b000;
    localparam logic [2:0] SEL_I    = 3'b001;
    localparam logic [2:0] SEL_S    = 3'b010;
    localparam logic [2:0] SEL_B    = 3'b011;
    localparam logic [2:0] SEL_J    = 3'b100;
    localparam logic [2:0] SEL_U    = 3'b101;

    // ig_in[k] carries instr[k+7]; instr[31] is ig_in[24].
    function automatic logic [XLEN-1:0] gen_imm(input logic [2:0] sel, input logic [24:0] ins);
        logic [31:0]     imm32;
        logic [XLEN-1:0] ext;
        case (sel)
            SEL_I:   imm32 = {{20{ins[24]}}, ins[24:13]};
            SEL_S:   imm32 = {{20{ins[24]}}, ins[24:18], ins[4:0]};
            SEL_B:   imm32 = {{19{ins[24]}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
            SEL_J:   imm32 = {{11{ins[24]}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
            SEL_U:   imm32 = {ins[24:5], 12'b0};
            default: imm32 = 32'b0;
        endcase
        // Every format carries its sign in bit 31, so widening to XLEN is uniform.
        ext       = {XLEN{imm32[31]}};
        ext[31:0] = imm32;
        return ext;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic            err_mem_r  [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [XLEN-1:0] last_imm_r;
    logic            err_sticky_r;

    logic            push_s;
    logic            pop_s;
    logic            sel_imm_s;
    logic            sel_rsv_s;
    logic [XLEN-1:0] push_data_s;

    assign in_ready   = (count_r < DEPTH_CNT);
    assign out_valid  = (count_r != '0);
    assign err_sticky = err_sticky_r;

    // A push coinciding with flush is discarded rather than queued.
    assign push_s = in_valid & in_ready & ~flush;
    assign pop_s  = out_valid & out_ready;

    // Classify the select and form the entry to be enqueued.
    always_comb begin
        sel_imm_s   = 1'b0;
        sel_rsv_s   = 1'b0;
        push_data_s = '0;
        case (ig_sel)
            SEL_HOLD: begin
                push_data_s = last_imm_r;
            end
            SEL_I, SEL_S, SEL_B, SEL_J, SEL_U: begin
                sel_imm_s   = 1'b1;
                push_data_s = gen_imm(ig_sel, ig_in);
            end
            default: begin
                sel_rsv_s   = 1'b1;
                push_data_s = '0;
            end
        endcase
    end

    // Head of queue; forced to zero when empty so no stale data leaks out.
    always_comb begin
        ig_out = '0;
        ig_err = 1'b0;
        if (out_valid) begin
            ig_out = data_mem_r[rd_ptr_r];
            ig_err = err_mem_r[rd_ptr_r];
        end else begin
            ig_out = '0;
            ig_err = 1'b0;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= push_data_s;
            err_mem_r[wr_ptr_r]  <= sel_rsv_s;
        end
    end

    // Pointer/count bookkeeping, last immediate and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            last_imm_r   <= '0;
            err_sticky_r <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= next_ptr(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= next_ptr(rd_ptr_r);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
            if (push_s && sel_imm_s) begin
                last_imm_r <= push_data_s;
            end
            if (push_s && sel_rsv_s) begin
                err_sticky_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ama_riscv_imm_gen_q.sv
// Directed testbench for ama_riscv_imm_gen_q (XLEN=32/DEPTH=2 plus an XLEN=64 instance).
module tb_ama_riscv_imm_gen_q;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  ig_sel = 3'b000;
    logic [24:0] ig_in = 25'b0;

    logic        in_ready, out_valid, ig_err, err_sticky;
    logic [31:0] ig_out;
    logic        in_ready64, out_valid64, ig_err64, err_sticky64;
    logic [63:0] ig_out64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ama_riscv_imm_gen_q #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ig_sel(ig_sel), .ig_in(ig_in), .out_valid(out_valid), .out_ready(out_ready),
        .ig_out(ig_out), .ig_err(ig_err), .err_sticky(err_sticky)
    );

    ama_riscv_imm_gen_q #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .ig_sel(ig_sel), .ig_in(ig_in), .out_valid(out_valid64), .out_ready(out_ready),
        .ig_out(ig_out64), .ig_err(ig_err64), .err_sticky(err_sticky64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] s, input logic [31:0] ins);
        ig_sel   = s;
        ig_in    = ins[31:7];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (ig_out !== 32'h0) begin errors++; $display("FAIL reset_ig_out got=%h exp=0", ig_out); end
        checks++; if (ig_err !== 1'b0) begin errors++; $display("FAIL reset_ig_err got=%b exp=0", ig_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
    endtask

    task automatic test_formats();
        push(3'b001, 32'hFFF00093);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL i_type_valid got=%b exp=1", out_valid); end
        checks++; if (ig_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL i_type got=%h exp=FFFFFFFF", ig_out); end
        pop_one();
        checks++; if (out_valid !== 1'b0 || ig_out !== 32'h0) begin errors++; $display("FAIL empty_zero valid=%b out=%h exp 0/0", out_valid, ig_out); end
        push(3'b011, 32'hFE000EE3);
        checks++; if (ig_out !== 32'hFFFFFFFC) begin errors++; $display("FAIL b_type got=%h exp=FFFFFFFC", ig_out); end
        pop_one();
        push(3'b010, 32'h00112423);
        checks++; if (ig_out !== 32'h00000008) begin errors++; $display("FAIL s_type got=%h exp=00000008", ig_out); end
        pop_one();
        push(3'b101, 32'h800000B7);
        checks++; if (ig_out !== 32'h80000000) begin errors++; $display("FAIL u_type32 got=%h exp=80000000", ig_out); end
        checks++; if (ig_out64 !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL u_type64 got=%h exp=FFFFFFFF80000000", ig_out64); end
        pop_one();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [3];
        int idx;
        logic accept;
        exp_q[0] = 32'd1; exp_q[1] = 32'd2; exp_q[2] = 32'd3;
        out_ready = 1'b0;
        push(3'b001, 32'h00100093);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1 got=%b exp=1", in_ready); end
        push(3'b001, 32'h00200093);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after2 got=%b exp=0", in_ready); end
        ig_sel = 3'b001; ig_in = 25'(32'h00300093 >> 7); in_valid = 1'b1;
        tick();
        checks++; if (ig_out !== 32'd1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_held head=%h ready=%b exp 1/0", ig_out, in_ready); end
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            if (out_valid) begin
                checks++; if (ig_out !== exp_q[idx]) begin errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", idx, ig_out, exp_q[idx]); end
                idx++;
            end
            accept = in_valid && in_ready;
            tick();
            if (accept) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (idx !== 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", idx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_hold_reserved();
        push(3'b100, 32'h0040006F);
        push(3'b000, 32'h0);
        checks++; if (ig_out !== 32'd4) begin errors++; $display("FAIL hold_j got=%h exp=4", ig_out); end
        pop_one();
        checks++; if (ig_out !== 32'd4 || ig_err !== 1'b0) begin errors++; $display("FAIL hold_rep got=%h err=%b exp 4/0", ig_out, ig_err); end
        pop_one();
        push(3'b110, 32'hFFFFFFFF);
        checks++; if (ig_out !== 32'd0 || ig_err !== 1'b1) begin errors++; $display("FAIL rsv got=%h err=%b exp 0/1", ig_out, ig_err); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL rsv_sticky got=%b exp=1", err_sticky); end
        pop_one();
        push(3'b000, 32'h0);
        checks++; if (ig_out !== 32'd4 || ig_err !== 1'b0) begin errors++; $display("FAIL hold_after_rsv got=%h err=%b exp 4/0", ig_out, ig_err); end
        pop_one();
    endtask

    task automatic test_flush();
        push(3'b001, 32'h00100093);
        push(3'b001, 32'h00200093);
        ig_sel = 3'b001; ig_in = 25'(32'h00500093 >> 7); in_valid = 1'b1; flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop valid=%b exp=0", out_valid); end
        push(3'b000, 32'h0);
        checks++; if (ig_out !== 32'd2) begin errors++; $display("FAIL flush_hold got=%h exp=2", ig_out); end
        pop_one();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL flush_sticky got=%b exp=1", err_sticky); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                ins = (32'(c + 1) << 20) | 32'h00000093;
                ig_sel = 3'b001; ig_in = ins[31:7]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (c > 0) begin
                checks++; if (ig_out !== 32'(c) || out_valid !== 1'b1) begin errors++; $display("FAIL wrap c=%0d got=%h valid=%b exp=%h", c, ig_out, out_valid, 32'(c)); end
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
        push(3'b001, 32'h00900093);
        ig_sel = 3'b001; ig_in = 25'(32'h00A00093 >> 7); in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || ig_out !== 32'h0 || ig_err !== 1'b0) begin errors++; $display("FAIL mid_rst valid=%b out=%h err=%b exp 0/0/0", out_valid, ig_out, ig_err); end
        checks++; if (in_ready !== 1'b1 || err_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_flags ready=%b sticky=%b exp 1/0", in_ready, err_sticky); end
        push(3'b000, 32'h0);
        checks++; if (out_valid !== 1'b1 || ig_out !== 32'h0) begin errors++; $display("FAIL rst_last_imm valid=%b out=%h exp 1/0", out_valid, ig_out); end
        pop_one();
    endtask

    initial begin
        #1;
        test_reset();
        test_formats();
        test_backpressure();
        test_hold_reserved();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
